wb_history_buf: RTL
===================

Name: wb_history_buf

Overview:
- Parametrised write-back history buffer for the forwarding pipeline; the generalised successor of the single extra WB pipeline register.
- Holds the last DEPTH retired write-back records (pc, inst, rd_addr, rd_wren, rd_data) in a shift structure.
- Entry 0 also drives the classic one-stage registered outputs.
- Provides two combinational forwarding lookup ports (rs1, rs2) that return the youngest matching record, so hazards older than one stage past WB are resolved without stalling.

Parameters:
- DEPTH, 2, number of history entries (>=1); entry 0 youngest, entry DEPTH-1 oldest.
- XLEN, 32, register data width (rd_data and lookup data).
- NOP_INST, 32'h0000_0013, instruction word stored in bubble entries.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous active-low reset.
- i_stall  in  1  1 = hold all entries.
- i_flush  in  1  1 = insert bubble instead of incoming record.
- i_valid  in  1  incoming record is a real instruction.
- i_pc  in  32  incoming PC.
- i_inst  in  32  incoming instruction.
- i_rd_addr  in  5  incoming destination register.
- i_rd_wren  in  1  incoming register write enable.
- i_rd_data  in  XLEN  incoming write-back data.
- o_pc  out  32  entry 0 PC.
- o_inst  out  32  entry 0 instruction.
- o_rd_addr  out  5  entry 0 rd address.
- o_rd_wren  out  1  entry 0 write enable, qualified by entry 0 valid.
- o_rd_data  out  XLEN  entry 0 data.
- o_valid  out  1  entry 0 valid.
- i_rs1_addr  in  5  lookup address, port 1.
- o_rs1_hit  out  1  port 1 match found.
- o_rs1_data  out  XLEN  port 1 forwarded data.
- i_rs2_addr  in  5  lookup address, port 2.
- o_rs2_hit  out  1  port 2 match found.
- o_rs2_data  out  XLEN  port 2 forwarded data.
- o_count  out  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Reset (i_reset=0, async, any time incl. mid-operation):
  - All entries: valid=0, pc=0, inst=0, rd_addr=0, rd_wren=0, rd_data=0.
  - Hence all o_* = 0, hits = 0, o_count = 0.
- Per rising edge, priority flush > stall > normal:
  - i_flush=1: shift (entry k <- entry k-1 for k>=1, oldest discarded); entry 0 <- bubble, regardless of i_stall.
  - Bubble contents: valid=0, pc=0, inst=NOP_INST, rd_addr=0, rd_wren=0, rd_data=0.
  - i_flush=0, i_stall=1: every entry holds; o_count holds.
  - i_flush=0, i_stall=0: shift; entry 0 <- incoming record if i_valid=1, else bubble.
- Older entries are committed instructions; flush never clears them, it only inserts a bubble.
- Latency: incoming record visible on o_* one cycle after capture; reaches entry k after k+1 unstalled edges.
- Lookup (combinational, per port):
  - Candidate entry requires valid=1, rd_wren=1, rd_addr == rs_addr, and rs_addr != 0.
  - Hit = any candidate; data = rd_data of lowest-index (youngest) candidate.
  - No hit: data = 0.
  - x0 never hits, even if a record wrote rd_addr=0 with wren=1.
- o_count = popcount(valid); saturates naturally at DEPTH; decreases as bubbles shift in.
- DEPTH=1: identical to a single stall/flush WB register plus the lookup ports.
- Lookup is independent of i_stall/i_flush in the same cycle; it reflects current register state only.

Test Plan:
- Reset: assert i_reset=0 mid-stream with DEPTH=2 full -> all o_* = 0, o_count=0, o_rs1_hit=0 immediately (async, before next edge).
- Shift: insert {pc=0x100, rd=5, data=0xAAAA}, then {pc=0x104, rd=6, data=0xBBBB} -> o_pc=0x104, o_count=2; rs1=5 hits 0xAAAA, rs2=6 hits 0xBBBB.
- Youngest wins: insert rd=7 data=0x11 then rd=7 data=0x22 -> rs1=7 returns 0x22; after two bubble inserts both entries are bubbles and rs1=7 misses, o_count=0.
- Stall vs flush: i_stall=1 with a new record -> outputs unchanged; i_stall=1 and i_flush=1 -> entry 0 = bubble (o_inst=0x13, o_valid=0), previous entry 0 moved to entry 1 and still forwardable.
- x0/wren filter: record rd=0 wren=1 data=0xDEAD and record rd=9 wren=0 -> rs1=0 and rs1=9 both hit=0, data=0.
- Eviction: DEPTH=2, three records rd=1,2,3 -> rs1=1 misses, rs2=2 and rs2=3 hit with their data.

Source files
------------

// File: rtl/wb_history_buf.sv
// wb_history_buf: shift history of the last DEPTH write-back records with
// entry-0 registered outputs and two youngest-match forwarding lookup ports.
`default_nettype none

module wb_history_buf #(
   parameter int          DEPTH    = 2,
   parameter int          XLEN     = 32,
   parameter logic [31:0] NOP_INST = 32'h0000_0013,
   localparam int         CW       = $clog2(DEPTH + 1)
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_stall,
   input  logic            i_flush,
   input  logic            i_valid,
   input  logic [31:0]     i_pc,
   input  logic [31:0]     i_inst,
   input  logic [4:0]      i_rd_addr,
   input  logic            i_rd_wren,
   input  logic [XLEN-1:0] i_rd_data,
   output logic [31:0]     o_pc,
   output logic [31:0]     o_inst,
   output logic [4:0]      o_rd_addr,
   output logic            o_rd_wren,
   output logic [XLEN-1:0] o_rd_data,
   output logic            o_valid,
   input  logic [4:0]      i_rs1_addr,
   output logic            o_rs1_hit,
   output logic [XLEN-1:0] o_rs1_data,
   input  logic [4:0]      i_rs2_addr,
   output logic            o_rs2_hit,
   output logic [XLEN-1:0] o_rs2_data,
   output logic [CW-1:0]   o_count
);

   logic [DEPTH-1:0]           valid_q, valid_d;
   logic [DEPTH-1:0][31:0]     pc_q, pc_d;
   logic [DEPTH-1:0][31:0]     inst_q, inst_d;
   logic [DEPTH-1:0][4:0]      rd_addr_q, rd_addr_d;
   logic [DEPTH-1:0]           rd_wren_q, rd_wren_d;
   logic [DEPTH-1:0][XLEN-1:0] rd_data_q, rd_data_d;

   logic take;
   assign take = !i_flush && i_valid;

   // Flush forces an advance even when stalled; entry 0 then becomes a bubble.
   always_comb begin
      valid_d   = valid_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      rd_addr_d = rd_addr_q;
      rd_wren_d = rd_wren_q;
      rd_data_d = rd_data_q;
      if (i_flush || !i_stall) begin
         for (int k = DEPTH - 1; k >= 1; k--) begin
            valid_d[k]   = valid_q[k-1];
            pc_d[k]      = pc_q[k-1];
            inst_d[k]    = inst_q[k-1];
            rd_addr_d[k] = rd_addr_q[k-1];
            rd_wren_d[k] = rd_wren_q[k-1];
            rd_data_d[k] = rd_data_q[k-1];
         end
         valid_d[0]   = take;
         pc_d[0]      = take ? i_pc      : 32'd0;
         inst_d[0]    = take ? i_inst    : NOP_INST;
         rd_addr_d[0] = take ? i_rd_addr : 5'd0;
         rd_wren_d[0] = take ? i_rd_wren : 1'b0;
         rd_data_d[0] = take ? i_rd_data : '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         valid_q   <= '0;
         pc_q      <= '0;
         inst_q    <= '0;
         rd_addr_q <= '0;
         rd_wren_q <= '0;
         rd_data_q <= '0;
      end else begin
         valid_q   <= valid_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         rd_addr_q <= rd_addr_d;
         rd_wren_q <= rd_wren_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign o_pc      = pc_q[0];
   assign o_inst    = inst_q[0];
   assign o_rd_addr = rd_addr_q[0];
   assign o_rd_wren = rd_wren_q[0] & valid_q[0];
   assign o_rd_data = rd_data_q[0];
   assign o_valid   = valid_q[0];

   // Scan oldest to youngest so the youngest matching entry is written last.
   always_comb begin
      o_rs1_hit  = 1'b0;
      o_rs1_data = '0;
      o_rs2_hit  = 1'b0;
      o_rs2_data = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (valid_q[k] && rd_wren_q[k] && (rd_addr_q[k] == i_rs1_addr) && (i_rs1_addr != 5'd0)) begin
            o_rs1_hit  = 1'b1;
            o_rs1_data = rd_data_q[k];
         end
         if (valid_q[k] && rd_wren_q[k] && (rd_addr_q[k] == i_rs2_addr) && (i_rs2_addr != 5'd0)) begin
            o_rs2_hit  = 1'b1;
            o_rs2_data = rd_data_q[k];
         end
      end
   end

   always_comb begin
      o_count = '0;
      for (int k = 0; k < DEPTH; k++) begin
         o_count = o_count + CW'(valid_q[k]);
      end
   end

endmodule

`default_nettype wire
